// File: rtl/lfsr4_checker_if.sv
// Bus between an LFSR word source (master) and the lfsr4_checker monitor (slave).
// err_cnt_o width follows ERR_W and must match the checker instance.
interface lfsr4_checker_if #(
    parameter int ERR_W = 16
);
    logic [3:0]       data_i;
    logic             valid_i;
    logic             clear_i;
    logic             locked_o;
    logic             err_o;
    logic [ERR_W-1:0] err_cnt_o;

    modport master (
        output data_i, valid_i, clear_i,
        input  locked_o, err_o, err_cnt_o
    );

    modport slave (
        input  data_i, valid_i, clear_i,
        output locked_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/lfsr4_checker.sv
// Self-synchronising checker for the 4-bit LFSR stream: seeds from the input,
// locks after a run of good predictions, then flywheels and counts mismatches.
module lfsr4_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic            clk,
    input  logic            reset,
    lfsr4_checker_if.slave  bus
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_TARGET = 4'(LOSS_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    function automatic logic [3:0] lfsr_next(input logic [3:0] c);
        return {c[2:0], c[3] ^ c[2]};
    endfunction

    logic [1:0]       state, state_n;
    logic [3:0]       expected, expected_n;
    logic [3:0]       hits, hits_n;
    logic [3:0]       misses, misses_n;
    logic             err_hit;
    logic             locked_q;
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic [3:0] hits_inc;
    logic [3:0] misses_inc;
    logic       word_match;
    logic       word_zero;

    assign hits_inc   = hits + 4'd1;
    assign misses_inc = misses + 4'd1;
    assign word_match = (bus.data_i == expected);
    assign word_zero  = (bus.data_i == 4'd0);

    // Only valid words advance anything; idle cycles hold every register.
    always_comb begin
        state_n    = state;
        expected_n = expected;
        hits_n     = hits;
        misses_n   = misses;
        err_hit    = 1'b0;
        if (bus.valid_i) begin
            case (state)
                SEARCH: begin
                    if (!word_zero) begin
                        expected_n = lfsr_next(bus.data_i);
                        hits_n     = 4'd0;
                        state_n    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (word_match) begin
                        expected_n = lfsr_next(bus.data_i);
                        hits_n     = hits_inc;
                        if (hits_inc == LOCK_TARGET) begin
                            state_n  = LOCKED;
                            misses_n = 4'd0;
                        end
                    end else if (!word_zero) begin
                        expected_n = lfsr_next(bus.data_i);
                        hits_n     = 4'd0;
                    end else begin
                        state_n = SEARCH;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction never follows a corrupted input word.
                    expected_n = lfsr_next(expected);
                    if (word_match) begin
                        misses_n = 4'd0;
                    end else begin
                        err_hit  = 1'b1;
                        misses_n = misses_inc;
                        if (misses_inc == LOSS_TARGET) begin
                            state_n = SEARCH;
                        end
                    end
                end
                default: begin
                    state_n = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            expected  <= 4'd0;
            hits      <= 4'd0;
            misses    <= 4'd0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state    <= state_n;
            expected <= expected_n;
            hits     <= hits_n;
            misses   <= misses_n;
            locked_q <= (state_n == LOCKED);
            err_q    <= err_hit;
            if (bus.clear_i) begin
                err_cnt_q <= '0;
            end else if (err_hit && (err_cnt_q != ERR_MAX)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.locked_o  = locked_q;
    assign bus.err_o     = err_q;
    assign bus.err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_lfsr4_checker.sv
// Randomised self-checking bench: a default checker and a narrow-counter variant
// share one stimulus stream and are compared against a behavioural model.
module tb_lfsr4_checker;

    logic       clk = 1'b0;
    logic       tb_rst = 1'b1;
    logic [3:0] tb_data = 4'd0;
    logic       tb_valid = 1'b0;
    logic       tb_clear = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfsr4_checker_if #(.ERR_W(16)) bus_a ();
    lfsr4_checker_if #(.ERR_W(2))  bus_b ();

    assign bus_a.data_i  = tb_data;
    assign bus_a.valid_i = tb_valid;
    assign bus_a.clear_i = tb_clear;
    assign bus_b.data_i  = tb_data;
    assign bus_b.valid_i = tb_valid;
    assign bus_b.clear_i = tb_clear;

    lfsr4_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut_a (
        .clk   (clk),
        .reset (tb_rst),
        .bus   (bus_a)
    );

    lfsr4_checker #(.LOCK_CNT(2), .LOSS_CNT(5), .ERR_W(2)) dut_b (
        .clk   (clk),
        .reset (tb_rst),
        .bus   (bus_b)
    );

    logic        obs_locked [2];
    logic        obs_err    [2];
    logic [15:0] obs_cnt    [2];

    always_comb begin
        obs_locked[0] = bus_a.locked_o;
        obs_locked[1] = bus_b.locked_o;
        obs_err[0]    = bus_a.err_o;
        obs_err[1]    = bus_b.err_o;
        obs_cnt[0]    = bus_a.err_cnt_o;
        obs_cnt[1]    = {14'd0, bus_b.err_cnt_o};
    end

    // Reference model: 0 = searching, 1 = verifying, 2 = locked.
    int p_lock [2] = '{4, 2};
    int p_loss [2] = '{3, 5};
    int p_max  [2] = '{65535, 3};
    int m_mode [2];
    int m_exp  [2];
    int m_hits [2];
    int m_miss [2];
    int m_cnt  [2];
    bit m_err  [2];
    bit m_lock [2];

    logic [3:0] cur;

    function automatic int gen_next(input int c);
        return ((c * 2) % 16) + ((((c / 8) ^ (c / 4)) % 2));
    endfunction

    task automatic model_update();
        int w;
        w = int'(tb_data);
        for (int d = 0; d < 2; d++) begin
            if (tb_rst) begin
                m_mode[d] = 0; m_exp[d] = 0; m_hits[d] = 0; m_miss[d] = 0;
                m_cnt[d] = 0; m_err[d] = 0; m_lock[d] = 0;
            end else begin
                m_err[d] = 0;
                if (tb_valid) begin
                    if (m_mode[d] == 0) begin
                        if (w != 0) begin
                            m_exp[d] = gen_next(w); m_hits[d] = 0; m_mode[d] = 1;
                        end
                    end else if (m_mode[d] == 1) begin
                        if (w == m_exp[d]) begin
                            m_hits[d] = m_hits[d] + 1;
                            m_exp[d] = gen_next(w);
                            if (m_hits[d] == p_lock[d]) begin
                                m_mode[d] = 2; m_miss[d] = 0;
                            end
                        end else if (w != 0) begin
                            m_exp[d] = gen_next(w); m_hits[d] = 0;
                        end else begin
                            m_mode[d] = 0;
                        end
                    end else begin
                        if (w == m_exp[d]) begin
                            m_miss[d] = 0;
                        end else begin
                            m_err[d] = 1;
                            if (m_cnt[d] < p_max[d]) m_cnt[d] = m_cnt[d] + 1;
                            m_miss[d] = m_miss[d] + 1;
                            if (m_miss[d] == p_loss[d]) m_mode[d] = 0;
                        end
                        m_exp[d] = gen_next(m_exp[d]);
                    end
                end
                if (tb_clear) m_cnt[d] = 0;
                m_lock[d] = (m_mode[d] == 2);
            end
        end
    endtask

    task automatic step(input logic v, input logic [3:0] w, input logic clr, input logic rst);
        @(negedge clk);
        tb_valid = v;
        tb_data  = w;
        tb_clear = clr;
        tb_rst   = rst;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic next_word(output logic [3:0] w);
        w   = cur;
        cur = 4'(gen_next(int'(cur)));
    endtask

    task automatic test_reset();
        step(1'b0, 4'd0, 1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({obs_locked[d], obs_err[d], obs_cnt[d]} !== 18'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got locked=%b err=%b cnt=%0d, want all zero",
                         d, obs_locked[d], obs_err[d], obs_cnt[d]);
            end
        end
    endtask

    task automatic test_acquisition();
        logic [3:0] words [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, words[i], 1'b0, 1'b0);
            n_checks++;
            if (obs_locked[0] !== (i == 4)) begin
                n_fail++;
                $display("FAIL acq_locked word%0d: got %b, want %b", i, obs_locked[0], (i == 4));
            end
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({obs_locked[d], obs_err[d], obs_cnt[d]} !== {m_lock[d], m_err[d], 16'(m_cnt[d])}) begin
                    n_fail++;
                    $display("FAIL acq dut%0d word%0d: got locked=%b err=%b cnt=%0d, want %b %b %0d",
                             d, i, obs_locked[d], obs_err[d], obs_cnt[d], m_lock[d], m_err[d], m_cnt[d]);
                end
            end
        end
        cur = 4'b0110;
    endtask

    task automatic test_single_error();
        logic [3:0] words [5] = '{4'b0110, 4'b1101, 4'b0000, 4'b0101, 4'b1011};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, words[i], 1'b0, 1'b0);
            n_checks++;
            if ({obs_locked[0], obs_err[0]} !== {1'b1, (i == 2)}) begin
                n_fail++;
                $display("FAIL single_err word%0d: got locked=%b err=%b, want 1 %b",
                         i, obs_locked[0], obs_err[0], (i == 2));
            end
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({obs_locked[d], obs_err[d], obs_cnt[d]} !== {m_lock[d], m_err[d], 16'(m_cnt[d])}) begin
                    n_fail++;
                    $display("FAIL single_err dut%0d word%0d: got locked=%b err=%b cnt=%0d, want %b %b %0d",
                             d, i, obs_locked[d], obs_err[d], obs_cnt[d], m_lock[d], m_err[d], m_cnt[d]);
                end
            end
        end
        n_checks++;
        if (obs_cnt[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL single_err_cnt: got %0d, want 1", obs_cnt[0]);
        end
        cur = 4'b0111;
    endtask

    task automatic test_loss_reacquire();
        logic [3:0] w;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd0, 1'b0, 1'b0);
            next_word(w);
            n_checks++;
            if ({obs_locked[0], obs_err[0]} !== {(i != 2), 1'b1}) begin
                n_fail++;
                $display("FAIL loss word%0d: got locked=%b err=%b, want %b 1",
                         i, obs_locked[0], obs_err[0], (i != 2));
            end
        end
        n_checks++;
        if (obs_cnt[0] !== 16'd4) begin
            n_fail++;
            $display("FAIL loss_cnt: got %0d, want 4", obs_cnt[0]);
        end
        cur = 4'($urandom_range(1, 15));
        for (int i = 0; i < 5; i++) begin
            next_word(w);
            step(1'b1, w, 1'b0, 1'b0);
            n_checks++;
            if (obs_locked[0] !== (i == 4)) begin
                n_fail++;
                $display("FAIL reacq_locked word%0d: got %b, want %b", i, obs_locked[0], (i == 4));
            end
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({obs_locked[d], obs_err[d], obs_cnt[d]} !== {m_lock[d], m_err[d], 16'(m_cnt[d])}) begin
                    n_fail++;
                    $display("FAIL reacq dut%0d word%0d: got locked=%b err=%b cnt=%0d, want %b %b %0d",
                             d, i, obs_locked[d], obs_err[d], obs_cnt[d], m_lock[d], m_err[d], m_cnt[d]);
                end
            end
        end
    endtask

    task automatic test_zero_and_gaps();
        logic [3:0] w;
        int nvalid;
        step(1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'd0, 1'b0, 1'b0);
            n_checks++;
            if ({obs_locked[0], obs_cnt[0], obs_locked[1], obs_cnt[1]} !== 34'd0) begin
                n_fail++;
                $display("FAIL zero_stream word%0d: got locked=%b/%b cnt=%0d/%0d, want 0",
                         i, obs_locked[0], obs_locked[1], obs_cnt[0], obs_cnt[1]);
            end
        end
        cur = 4'($urandom_range(1, 15));
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                next_word(w);
                step(1'b1, w, 1'b0, 1'b0);
                nvalid++;
            end else begin
                step(1'b0, 4'($urandom), 1'b0, 1'b0);
            end
            n_checks++;
            if (obs_locked[0] !== (nvalid >= 5)) begin
                n_fail++;
                $display("FAIL gaps_locked cycle%0d: got %b, want %b", i, obs_locked[0], (nvalid >= 5));
            end
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({obs_locked[d], obs_err[d], obs_cnt[d]} !== {m_lock[d], m_err[d], 16'(m_cnt[d])}) begin
                    n_fail++;
                    $display("FAIL gaps dut%0d cycle%0d: got locked=%b err=%b cnt=%0d, want %b %b %0d",
                             d, i, obs_locked[d], obs_err[d], obs_cnt[d], m_lock[d], m_err[d], m_cnt[d]);
                end
            end
        end
    endtask

    task automatic test_saturation_clear();
        logic [3:0] w;
        for (int i = 0; i < 10; i++) begin
            next_word(w);
            if (i % 2 == 0) w = w ^ 4'($urandom_range(1, 15));
            step(1'b1, w, 1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({obs_locked[d], obs_err[d], obs_cnt[d]} !== {m_lock[d], m_err[d], 16'(m_cnt[d])}) begin
                    n_fail++;
                    $display("FAIL sat dut%0d word%0d: got locked=%b err=%b cnt=%0d, want %b %b %0d",
                             d, i, obs_locked[d], obs_err[d], obs_cnt[d], m_lock[d], m_err[d], m_cnt[d]);
                end
            end
        end
        n_checks++;
        if (obs_cnt[1] !== 16'd3) begin
            n_fail++;
            $display("FAIL sat_cap: got %0d, want 3", obs_cnt[1]);
        end
        next_word(w);
        step(1'b1, w ^ 4'($urandom_range(1, 15)), 1'b1, 1'b0);
        n_checks++;
        if ({obs_err[0], obs_cnt[0], obs_err[1], obs_cnt[1]} !== {1'b1, 16'd0, 1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL clear_vs_err: got err=%b/%b cnt=%0d/%0d, want 1/1 0/0",
                     obs_err[0], obs_err[1], obs_cnt[0], obs_cnt[1]);
        end
    endtask

    task automatic test_reset_mid_lock();
        logic [3:0] w;
        next_word(w);
        step(1'b1, w, 1'b0, 1'b1);
        n_checks++;
        if ({obs_locked[0], obs_err[0], obs_cnt[0], obs_locked[1]} !== 19'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got locked=%b err=%b cnt=%0d lockedB=%b, want 0",
                     obs_locked[0], obs_err[0], obs_cnt[0], obs_locked[1]);
        end
        cur = 4'($urandom_range(1, 15));
        for (int i = 0; i < 5; i++) begin
            next_word(w);
            step(1'b1, w, 1'b0, 1'b0);
            n_checks++;
            if (obs_locked[0] !== (i == 4)) begin
                n_fail++;
                $display("FAIL relock word%0d: got %b, want %b", i, obs_locked[0], (i == 4));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] w;
        logic v, clr, rst;
        for (int i = 0; i < 800; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 59) == 0) cur = 4'($urandom_range(0, 15));
            if (cur == 4'd0 && $urandom_range(0, 9) == 0) cur = 4'($urandom_range(1, 15));
            w = 4'($urandom);
            if (v) begin
                next_word(w);
                if ($urandom_range(0, 7) == 0) w = w ^ 4'($urandom_range(1, 15));
            end
            step(v, w, clr, rst);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if ({obs_locked[d], obs_err[d], obs_cnt[d]} !== {m_lock[d], m_err[d], 16'(m_cnt[d])}) begin
                    n_fail++;
                    $display("FAIL random dut%0d cycle%0d: got locked=%b err=%b cnt=%0d, want %b %b %0d",
                             d, i, obs_locked[d], obs_err[d], obs_cnt[d], m_lock[d], m_err[d], m_cnt[d]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w;
        step(1'b0, 4'd0, 1'b0, 1'b1);
        cur = 4'($urandom_range(1, 15));
        for (int i = 0; i < 5; i++) begin
            next_word(w);
            step(1'b1, w, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            next_word(w);
            step(1'b1, w ^ 4'($urandom_range(1, 15)), 1'b0, 1'b0);
            n_checks++;
            if ({obs_err[0], obs_cnt[0]} !== {1'b1, 16'(i + 1)}) begin
                n_fail++;
                $display("FAIL back_to_back err%0d: got err=%b cnt=%0d, want 1 %0d",
                         i, obs_err[0], obs_cnt[0], i + 1);
            end
        end
        step(1'b0, 4'd0, 1'b0, 1'b0);
        n_checks++;
        if ({obs_err[0], obs_locked[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL back_to_back_idle: got err=%b locked=%b, want 0 0", obs_err[0], obs_locked[0]);
        end
    endtask

    initial begin
        cur = 4'd1;
        test_reset();
        test_acquisition();
        test_single_error();
        test_loss_reacquire();
        test_zero_and_gaps();
        test_saturation_clear();
        test_reset_mid_lock();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr4_checker.md
# lfsr4_checker

Downstream consumer of the 4-bit LFSR stage. Samples the LFSR output word stream, self-synchronises a local copy of the same generator, declares lock after a run of correct predictions, and then counts mismatches against a free-running (flywheel) prediction. Used as the on-chip pass/fail monitor for the pseudo-random pattern generator.

## Interface
- LOCK_CNT, default 4: consecutive correct predictions after seeding needed to enter LOCKED (range 1..15).
- LOSS_CNT, default 3: consecutive mismatches in LOCKED that drop lock (range 1..15).
- ERR_W, default 16: width of the saturating error counter (≥2).
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the sampling edge.
- data_i  in  4  LFSR word from upstream stage.
- valid_i  in  1  data_i is a new sequence word this cycle.
- clear_i  in  1  synchronous clear of err_cnt_o; no effect on lock state.
- locked_o  out  1  registered, high while in LOCKED.
- err_o  out  1  registered one-cycle pulse per mismatch counted in LOCKED.
- err_cnt_o  out  ERR_W  saturating count of mismatches in LOCKED.

## Operation
- Generator: next(c) = {c[2:0], c[3]^c[2]}; period 15; 4'b0000 is the lock-up word and never a valid seed.
- Internal: state (SEARCH, VERIFY, LOCKED), expected[3:0], hit counter, miss counter.
- Cycles with valid_i=0: no state, counter or expected change; err_o=0.
- SEARCH: valid word ≠0 → expected=next(data_i), hits=0, go VERIFY. Word =0 → stay.
- VERIFY: data_i==expected → hits+1, expected=next(data_i); when hits reaches LOCK_CNT → LOCKED, misses=0. Mismatch → reseed: if data_i≠0, expected=next(data_i), hits=0, stay VERIFY; if 0, go SEARCH. No errors counted in SEARCH/VERIFY.
- LOCKED: expected=next(expected) on every valid word (flywheel, never reseeded from data_i). Match → misses=0. Mismatch → err_o pulse, err_cnt+1 (saturates at 2^ERR_W−1), misses+1; when misses reaches LOSS_CNT → SEARCH, locked_o drops.
- clear_i and a counted error in the same cycle: clear wins, err_cnt_o=0; err_o still pulses.
- Reset values: state SEARCH, expected 0, hits 0, misses 0, locked_o 0, err_o 0, err_cnt_o 0. Reset mid-stream discards lock; reacquisition restarts from SEARCH.

## Timing
- All outputs registered; each reflects the valid word sampled on the previous rising edge.
- Lock latency: 1 seed word + LOCK_CNT matching words; locked_o high in the cycle after the edge sampling the last of them (5 valid words at default).
- err_o: high exactly one cycle after the edge sampling the mismatching word; back-to-back mismatches give back-to-back pulses.
- Loss: locked_o low in the cycle after the edge sampling the LOSS_CNT-th consecutive mismatch; that mismatch is still counted and pulsed.
- valid_i gaps of any length do not break VERIFY or LOCKED progress.
- reset has priority over valid_i and clear_i.

## Test plan
- Acquisition: after reset, feed 0001,0010,0100,1001,0011 with valid_i=1 each cycle → locked_o=1 after the 5th edge, err_cnt_o=0; locked_o=0 for all earlier cycles.
- Single error: locked, continuing sequence 0110,1101, inject 0000 instead of 1010, then 0101,1011 → one err_o pulse, err_cnt_o=1, locked_o stays 1, following words match.
- Loss and reacquire: locked, send three wrong words (e.g. 1111,1111,1111 where 0111,1111,1110 expected... use 0000×3) → err_cnt_o=3, locked_o falls after the 3rd; resume valid sequence → locked_o returns after 5 words.
- Zero stream and gaps: after reset, 20 valid 0000 words → stays SEARCH, locked_o=0, err_cnt_o=0; then valid sequence with valid_i toggling every other cycle → still locks after 5 valid words.
- Saturation and clear: ERR_W=2, locked, alternate wrong/right words for 5 errors → err_cnt_o stops at 3; assert clear_i together with a 6th error → err_cnt_o=0, err_o pulses.
- Reset mid-lock: locked, assert reset for 1 cycle → next cycle locked_o=0, err_o=0, err_cnt_o=0; resume stream → relock after 5 valid words.
